// File: rtl/dm_bus_bridge.sv
// Data-memory bus bridge: turns MEM-stage loads/stores into single word-aligned
// bus transactions with byte-lane enables, wait-state timeout and load extension.
module dm_bus_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_dmtype,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } state_t;

  // The counter only ever holds 0..TIMEOUT-1; reaching TIMEOUT leaves BUSY.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          legal_s, accept_s, load_ack_s;
  logic          bus_req_r, bus_we_r, cpu_err_r;
  logic [31:0]   bus_addr_r, bus_wdata_r, cpu_rdata_r;
  logic [3:0]    bus_be_r;
  logic [1:0]    off_r;
  logic [2:0]    type_r;

  function automatic logic access_legal(input logic [2:0] t, input logic [1:0] off);
    logic ok;
    case (t)
      3'b000:         ok = (off == 2'b00);
      3'b001, 3'b010: ok = (off[0] == 1'b0);
      3'b011, 3'b100: ok = 1'b1;
      default:        ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] t, input logic [1:0] off);
    logic [3:0] m;
    case (t)
      3'b000:         m = 4'b1111;
      3'b001, 3'b010: m = off[1] ? 4'b1100 : 4'b0011;
      3'b011, 3'b100: m = 4'b0001 << off;
      default:        m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] t, input logic [31:0] d);
    logic [31:0] r;
    case (t)
      3'b001, 3'b010: r = {2{d[15:0]}};
      3'b011, 3'b100: r = {4{d[7:0]}};
      default:        r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] t, input logic [1:0] off,
                                              input logic [31:0] d);
    logic [31:0] sh;
    logic [31:0] r;
    sh = d >> {off, 3'b000};
    case (t)
      3'b001:  r = {{16{sh[15]}}, sh[15:0]};
      3'b010:  r = {16'h0000, sh[15:0]};
      3'b011:  r = {{24{sh[7]}}, sh[7:0]};
      3'b100:  r = {24'h000000, sh[7:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

  assign legal_s = access_legal(cpu_dmtype, cpu_addr[1:0]);

  // Next-state, wait counter and accept/ack strobes.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    accept_s   = 1'b0;
    load_ack_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cpu_req) begin
          if (legal_s) begin
            state_s  = BUSY;
            accept_s = 1'b1;
            cnt_s    = '0;
          end else begin
            state_s = ERR;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        // An ack in the same cycle the counter expires still completes normally.
        if (bus_ack) begin
          state_s    = DONE;
          cnt_s      = '0;
          load_ack_s = ~bus_we_r;
        end else if ((TIMEOUT > 0) && (cnt_r == CNT_LAST)) begin
          state_s = ERR;
          cnt_s   = '0;
        end else if (TIMEOUT > 0) begin
          cnt_s = cnt_r + CW'(1);
        end else begin
          cnt_s = cnt_r;
        end
      end
      DONE:    state_s = IDLE;
      ERR:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, counter and the per-state registered strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      bus_req_r <= 1'b0;
      cpu_err_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bus_req_r <= (state_s == BUSY);
      cpu_err_r <= (state_s == ERR);
    end
  end

  // Capture the bus-side view of an accepted request; held until the next accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_we_r    <= 1'b0;
      bus_addr_r  <= 32'h0000_0000;
      bus_be_r    <= 4'b0000;
      bus_wdata_r <= 32'h0000_0000;
      off_r       <= 2'b00;
      type_r      <= 3'b000;
    end else if (accept_s) begin
      bus_we_r    <= cpu_we;
      bus_addr_r  <= {cpu_addr[31:2], 2'b00};
      bus_be_r    <= lane_mask(cpu_dmtype, cpu_addr[1:0]);
      bus_wdata_r <= lane_data(cpu_dmtype, cpu_wdata);
      off_r       <= cpu_addr[1:0];
      type_r      <= cpu_dmtype;
    end else begin
      bus_we_r    <= bus_we_r;
      bus_addr_r  <= bus_addr_r;
      bus_be_r    <= bus_be_r;
      bus_wdata_r <= bus_wdata_r;
      off_r       <= off_r;
      type_r      <= type_r;
    end
  end

  // Load result register, updated only on a load ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rdata_r <= 32'h0000_0000;
    end else if (load_ack_s) begin
      cpu_rdata_r <= load_extend(type_r, off_r, bus_rdata);
    end else begin
      cpu_rdata_r <= cpu_rdata_r;
    end
  end

  // Stall must track cpu_req in the same cycle, so it is decoded from state.
  assign cpu_stall = reset & cpu_req & ((state_r == IDLE) | (state_r == BUSY));
  assign cpu_rdata = cpu_rdata_r;
  assign cpu_err   = cpu_err_r;
  assign bus_req   = bus_req_r;
  assign bus_we    = bus_we_r;
  assign bus_addr  = bus_addr_r;
  assign bus_be    = bus_be_r;
  assign bus_wdata = bus_wdata_r;

endmodule

// File: tb/tb_dm_bus_bridge.sv
// Bench for dm_bus_bridge: directed scenarios plus randomized accesses checked
// against a byte-level reference model.
module tb_dm_bus_bridge;

  localparam int TO = 4;

  logic        clk, reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [2:0]  cpu_dmtype;
  logic [31:0] cpu_rdata;
  logic        cpu_stall, cpu_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] last_rd = 32'h0;

  typedef struct packed {
    int          stall;
    int          req;
    logic        err;
    logic        done_req;
    logic        stable;
    logic        fin;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } result_t;

  dm_bus_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_dmtype(cpu_dmtype), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_err(cpu_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: access size in bytes, alignment, lane replication and extension.
  function automatic result_t model(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                    input logic [2:0] t, input int delay, input logic [31:0] brd,
                                    input logic [31:0] prev);
    result_t e;
    int size, off;
    bit sgn, ok;
    longint v;
    e = '0; e.stable = 1'b1; e.fin = 1'b1; e.rdata = prev;
    ok = 1'b1; size = 4; sgn = 1'b0;
    case (t)
      3'd0: size = 4;
      3'd1: begin size = 2; sgn = 1'b1; end
      3'd2: size = 2;
      3'd3: begin size = 1; sgn = 1'b1; end
      3'd4: size = 1;
      default: ok = 1'b0;
    endcase
    off = int'(addr % 4);
    if (!ok || (off % size) != 0) begin
      e.stall = 1; e.req = 0; e.err = 1'b1;
      return e;
    end
    e.addr = addr - 32'(off);
    e.be   = 4'(((1 << size) - 1) << off);
    e.we   = we;
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
    if (delay >= TO) begin
      e.req = TO; e.stall = TO + 1; e.err = 1'b1;
    end else begin
      e.req = delay + 1; e.stall = delay + 2;
      if (!we) begin
        v = (longint'(brd) >> (8 * off)) & ((64'sd1 <<< (8 * size)) - 1);
        if (sgn && v >= (64'sd1 <<< (8 * size - 1))) v = v - (64'sd1 <<< (8 * size));
        e.rdata = v[31:0];
      end
    end
    return e;
  endfunction

  // Drives one access starting at the next falling edge; samples at negedge+1.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [2:0] t, input int delay, input logic [31:0] brd,
                           output result_t r);
    r = '0; r.stable = 1'b1;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_dmtype = t;
    for (int c = 0; c < 60; c++) begin
      #1;
      bus_ack = 1'b0;
      if (bus_req) begin
        if (r.req == 0) begin
          r.addr = bus_addr; r.be = bus_be; r.wdata = bus_wdata; r.we = bus_we;
        end else if ({bus_addr, bus_be, bus_wdata, bus_we} !== {r.addr, r.be, r.wdata, r.we}) begin
          r.stable = 1'b0;
        end
        r.req++;
        if (r.req == delay + 1) begin bus_ack = 1'b1; bus_rdata = brd; end
      end
      if (cpu_stall) begin
        r.stall++;
      end else begin
        r.err = cpu_err; r.done_req = bus_req; r.rdata = cpu_rdata; r.fin = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0104;
    cpu_wdata = 32'hFFFF_FFFF; cpu_dmtype = 3'd0; bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if ({cpu_stall, bus_req, bus_we, cpu_err} !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_ctrl: got %b want 0000", {cpu_stall, bus_req, bus_we, cpu_err});
    end
    tests_run++;
    if ({bus_addr, bus_be, bus_wdata, cpu_rdata} !== 100'h0) begin
      tests_failed++; $display("FAIL reset_data: got addr %h be %b wd %h rd %h want 0", bus_addr, bus_be, bus_wdata, cpu_rdata);
    end
    cpu_req = 1'b0; bus_ack = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    tests_run++;
    if ({cpu_stall, bus_req, cpu_err} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_idle: got %b want 000", {cpu_stall, bus_req, cpu_err});
    end
  endtask

  task automatic test_lb();
    result_t r;
    do_access(1'b0, 32'h0000_0103, 32'h0, 3'd3, 0, 32'h80FF_1234, r);
    cpu_req = 1'b0;
    tests_run++;
    if (r.be !== 4'b1000) begin tests_failed++; $display("FAIL lb_be: got %b want 1000", r.be); end
    tests_run++;
    if (r.stall !== 2 || r.req !== 1 || !r.fin) begin
      tests_failed++; $display("FAIL lb_timing: got stall %0d req %0d want 2 1", r.stall, r.req);
    end
    tests_run++;
    if (r.rdata !== 32'hFFFF_FF80 || r.err !== 1'b0) begin
      tests_failed++; $display("FAIL lb_rdata: got %h err %b want ffffff80 0", r.rdata, r.err);
    end
    last_rd = 32'hFFFF_FF80;
  endtask

  task automatic test_sh_wait();
    result_t r;
    do_access(1'b1, 32'h0000_0202, 32'h0000_BEEF, 3'd1, 3, 32'h1111_1111, r);
    cpu_req = 1'b0;
    tests_run++;
    if (r.addr !== 32'h0000_0200 || r.be !== 4'b1100 || r.we !== 1'b1) begin
      tests_failed++; $display("FAIL sh_bus: got addr %h be %b we %b want 00000200 1100 1", r.addr, r.be, r.we);
    end
    tests_run++;
    if (r.wdata !== 32'hBEEF_BEEF || !r.stable) begin
      tests_failed++; $display("FAIL sh_wdata: got %h stable %b want beefbeef 1", r.wdata, r.stable);
    end
    tests_run++;
    if (r.stall !== 5 || r.err !== 1'b0 || r.rdata !== last_rd) begin
      tests_failed++; $display("FAIL sh_timing: got stall %0d err %b rd %h want 5 0 %h", r.stall, r.err, r.rdata, last_rd);
    end
  endtask

  task automatic test_illegal();
    result_t r;
    do_access(1'b0, 32'h0000_0101, 32'h0, 3'd0, 0, 32'h0, r);
    cpu_req = 1'b0;
    tests_run++;
    if (r.req !== 0 || r.stall !== 1 || r.err !== 1'b1) begin
      tests_failed++; $display("FAIL lw_misaligned: got req %0d stall %0d err %b want 0 1 1", r.req, r.stall, r.err);
    end
    @(negedge clk); #1;
    tests_run++;
    if (cpu_err !== 1'b0 || bus_req !== 1'b0) begin
      tests_failed++; $display("FAIL err_pulse_len: got err %b req %b want 0 0", cpu_err, bus_req);
    end
  endtask

  task automatic test_timeout();
    result_t r;
    do_access(1'b0, 32'h0000_0400, 32'h0, 3'd0, 100, 32'h0, r);
    cpu_req = 1'b0;
    tests_run++;
    if (r.req !== TO || r.stall !== TO + 1 || r.err !== 1'b1 || r.done_req !== 1'b0) begin
      tests_failed++; $display("FAIL timeout: got req %0d stall %0d err %b dreq %b want 4 5 1 0", r.req, r.stall, r.err, r.done_req);
    end
    @(negedge clk); #1;
    tests_run++;
    if (cpu_err !== 1'b0 || cpu_rdata !== last_rd) begin
      tests_failed++; $display("FAIL timeout_after: got err %b rd %h want 0 %h", cpu_err, cpu_rdata, last_rd);
    end
  endtask

  task automatic test_back_to_back();
    result_t r1, r2;
    do_access(1'b0, 32'h0000_0300, 32'h0, 3'd2, 0, 32'hA5A5_8001, r1);
    do_access(1'b0, 32'h0000_0304, 32'h0, 3'd0, 0, 32'h1234_5678, r2);
    cpu_req = 1'b0;
    tests_run++;
    if (r1.rdata !== 32'h0000_8001 || r1.done_req !== 1'b0 || r1.stall !== 2) begin
      tests_failed++; $display("FAIL b2b_lhu: got rd %h dreq %b stall %0d want 00008001 0 2", r1.rdata, r1.done_req, r1.stall);
    end
    tests_run++;
    if (r2.rdata !== 32'h1234_5678 || r2.addr !== 32'h0000_0304 || r2.stall !== 2 || r2.req !== 1) begin
      tests_failed++; $display("FAIL b2b_lw: got rd %h addr %h stall %0d req %0d want 12345678 00000304 2 1", r2.rdata, r2.addr, r2.stall, r2.req);
    end
    last_rd = 32'h1234_5678;
  endtask

  task automatic test_random();
    result_t r, e;
    logic we;
    logic [31:0] addr, wd, brd;
    logic [2:0] t;
    int delay;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom); t = 3'($urandom_range(0, 5));
      addr = $urandom; wd = $urandom; brd = $urandom; delay = $urandom_range(0, 5);
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      e = model(we, addr, wd, t, delay, brd, last_rd);
      do_access(we, addr, wd, t, delay, brd, r);
      cpu_req = 1'b0;
      last_rd = e.rdata;
      tests_run++;
      if (r.fin !== 1'b1 || r.stall !== e.stall || r.req !== e.req || r.err !== e.err || r.done_req !== 1'b0) begin
        tests_failed++;
        $display("FAIL rnd%0d_ctrl: got stall %0d req %0d err %b want %0d %0d %b", i, r.stall, r.req, r.err, e.stall, e.req, e.err);
      end
      tests_run++;
      if (r.rdata !== e.rdata) begin
        tests_failed++; $display("FAIL rnd%0d_rdata: got %h want %h (t %0d a %h)", i, r.rdata, e.rdata, t, addr);
      end
      if (e.req > 0) begin
        tests_run++;
        if ({r.addr, r.be, r.wdata, r.we, r.stable} !== {e.addr, e.be, e.wdata, e.we, 1'b1}) begin
          tests_failed++;
          $display("FAIL rnd%0d_bus: got %h %b %h %b st %b want %h %b %h %b", i, r.addr, r.be, r.wdata, r.we, r.stable, e.addr, e.be, e.wdata, e.we);
        end
      end
    end
  endtask

  task automatic test_reset_busy();
    result_t r;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0500; cpu_dmtype = 3'd0;
    @(negedge clk); #1;
    tests_run++;
    if (bus_req !== 1'b1) begin tests_failed++; $display("FAIL rst_busy_pre: got req %b want 1", bus_req); end
    reset = 1'b0; #1;
    tests_run++;
    if (bus_req !== 1'b0 || cpu_stall !== 1'b0 || cpu_rdata !== 32'h0) begin
      tests_failed++; $display("FAIL rst_busy_now: got req %b stall %b rd %h want 0 0 0", bus_req, cpu_stall, cpu_rdata);
    end
    @(negedge clk); reset = 1'b1; cpu_req = 1'b0; bus_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      tests_run++;
      if ({cpu_err, bus_req, cpu_stall} !== 3'b000 || cpu_rdata !== 32'h0) begin
        tests_failed++; $display("FAIL rst_busy_after%0d: got err/req/stall %b rd %h want 000 0", k, {cpu_err, bus_req, cpu_stall}, cpu_rdata);
      end
    end
    bus_ack = 1'b0;
    do_access(1'b0, 32'h0000_0602, 32'h0, 3'd1, 1, 32'hFFFF_0000, r);
    cpu_req = 1'b0;
    tests_run++;
    if (r.rdata !== 32'hFFFF_FFFF || r.stall !== 3 || r.be !== 4'b1100) begin
      tests_failed++; $display("FAIL rst_recover: got rd %h stall %0d be %b want ffffffff 3 1100", r.rdata, r.stall, r.be);
    end
  endtask

  initial begin
    bus_ack = 1'b0; bus_rdata = 32'h0;
    test_reset();
    test_lb();
    test_sh_wait();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
